// File: rtl/pio_pulse_out.sv
// Multi-bit output PIO slave with atomic set/clear and a one-shot pulse engine.
// out_port is the static DATA level with PMASK forced high while a pulse runs.
module pio_pulse_out #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      CNT_W       = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic StIdle  = 1'b0;
  localparam logic StPulse = 1'b1;

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] pmask_q, pmask_d;
  logic [CNT_W-1:0] plen_q, plen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             irq_en_q, irq_en_d;
  logic             done_q, done_d;
  logic             state_q, state_d;

  logic wr, ctrl_wr, start, done_clr, done_set, busy;
  logic unused_wdata;

  assign unused_wdata = ^writedata;

  assign wr       = chipselect & ~write_n;
  assign ctrl_wr  = wr && (address == 3'd3);
  assign start    = ctrl_wr & writedata[0];
  assign done_clr = ctrl_wr & writedata[2];
  assign busy     = (state_q == StPulse);

  always_comb begin
    data_d   = data_q;
    pmask_d  = pmask_q;
    plen_d   = plen_q;
    irq_en_d = irq_en_q;
    if (wr) begin
      case (address)
        3'd0:    data_d   = writedata[WIDTH-1:0];
        3'd1:    pmask_d  = writedata[WIDTH-1:0];
        3'd2:    plen_d   = writedata[CNT_W-1:0];
        3'd3:    irq_en_d = writedata[1];
        3'd4:    data_d   = data_q | writedata[WIDTH-1:0];
        3'd5:    data_d   = data_q & ~writedata[WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // START (including a retrigger) always reloads from PLEN; PLEN==0 finishes at once.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_set = 1'b0;
    if (start) begin
      if (plen_q != '0) begin
        state_d = StPulse;
        cnt_d   = plen_q;
      end else begin
        state_d  = StIdle;
        cnt_d    = '0;
        done_set = 1'b1;
      end
    end else if (state_q == StPulse) begin
      if (cnt_q == CNT_W'(1)) begin
        state_d  = StIdle;
        cnt_d    = '0;
        done_set = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // A completion on the same edge as DONE_CLR keeps DONE set.
  assign done_d = done_set ? 1'b1 : (done_clr ? 1'b0 : done_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q   <= RESET_VALUE;
      pmask_q  <= '0;
      plen_q   <= '0;
      cnt_q    <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      state_q  <= StIdle;
    end else begin
      data_q   <= data_d;
      pmask_q  <= pmask_d;
      plen_q   <= plen_d;
      cnt_q    <= cnt_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      state_q  <= state_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      3'd0:    readdata[WIDTH-1:0] = data_q;
      3'd1:    readdata[WIDTH-1:0] = pmask_q;
      3'd2:    readdata[CNT_W-1:0] = plen_q;
      3'd3:    readdata[2:0]       = {done_q, irq_en_q, busy};
      default: ;
    endcase
  end

  assign out_port = data_q | (busy ? pmask_q : '0);
  assign irq      = done_q & irq_en_q;

endmodule

// File: tb/tb_pio_pulse_out.sv
// Scoreboard bench for pio_pulse_out: a pulse is modelled as an absolute end edge,
// and expected pin/irq/readdata values are queued per edge for a separate monitor.
module tb_pio_pulse_out;

  localparam int unsigned  W  = 8;
  localparam int unsigned  CW = 24;
  localparam logic [W-1:0] RV = 8'hA5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    address = 3'd0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [W-1:0]  out_port;
  logic          irq;

  pio_pulse_out #(.WIDTH(W), .CNT_W(CW), .RESET_VALUE(RV)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] out;
    logic         irq;
    logic [31:0]  rd;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference state: a pulse is "pending" until the absolute edge number m_end.
  logic [W-1:0]  m_data = RV;
  logic [W-1:0]  m_pmask = '0;
  logic [CW-1:0] m_plen = '0;
  logic          m_irq_en = 1'b0;
  logic          m_done = 1'b0;
  logic          m_pending = 1'b0;
  longint        m_end = 0;
  longint        edge_n = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, edge_n, act, req);
    end
  endfunction

  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("out_port", 32'(out_port), 32'(mon_e.out));
      check("irq", 32'(irq), 32'(mon_e.irq));
      check("readdata", readdata, mon_e.rd);
    end
  end

  // One bus cycle: drive at the falling edge, predict the state after the next rising edge.
  task automatic op(input logic rst_n, input logic cs, input logic wn,
                    input logic [2:0] a, input logic [31:0] wd);
    logic start, clr, set, busy;
    exp_t e;
    @(negedge clk);
    reset_n    = rst_n;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    edge_n++;
    start = 1'b0;
    clr   = 1'b0;
    set   = 1'b0;
    if (!rst_n) begin
      m_data = RV; m_pmask = '0; m_plen = '0; m_irq_en = 1'b0;
      m_done = 1'b0; m_pending = 1'b0;
    end else begin
      if (cs && !wn) begin
        case (a)
          3'd0: m_data = wd[W-1:0];
          3'd1: m_pmask = wd[W-1:0];
          3'd2: m_plen = wd[CW-1:0];
          3'd3: begin m_irq_en = wd[1]; start = wd[0]; clr = wd[2]; end
          3'd4: m_data = m_data | wd[W-1:0];
          3'd5: m_data = m_data & ~wd[W-1:0];
          default: ;
        endcase
      end
      if (start) begin
        m_pending = 1'b1;
        m_end     = edge_n + longint'(m_plen);
      end
      if (m_pending && m_end == edge_n) begin
        set       = 1'b1;
        m_pending = 1'b0;
      end
      m_done = set ? 1'b1 : (clr ? 1'b0 : m_done);
    end
    busy  = m_pending && (edge_n < m_end);
    e.out = m_data | (busy ? m_pmask : '0);
    e.irq = m_done & m_irq_en;
    case (a)
      3'd0:    e.rd = 32'(m_data);
      3'd1:    e.rd = 32'(m_pmask);
      3'd2:    e.rd = 32'(m_plen);
      3'd3:    e.rd = {29'd0, m_done, m_irq_en, busy};
      default: e.rd = '0;
    endcase
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    op(1'b1, 1'b1, 1'b0, a, wd);
  endtask

  task automatic idle(input int n, input logic [2:0] a);
    for (int i = 0; i < n; i++) op(1'b1, 1'b0, 1'b1, a, 32'hDEAD_BEEF);
  endtask

  initial begin
    // Reset held for several cycles while reading every mapped address.
    for (int i = 0; i < 6; i++) op(1'b0, 1'b0, 1'b1, 3'(i), '0);
    // DATA write with truncation, then OUTSET and OUTCLR.
    wr(3'd0, 32'h1234_56F0);
    wr(3'd4, 32'h0000_000F);
    wr(3'd5, 32'h0000_0030);
    idle(1, 3'd0);
    // Single pulse of 5 with irq enabled.
    wr(3'd1, 32'h01);
    wr(3'd2, 32'd5);
    wr(3'd0, 32'h00);
    wr(3'd3, 32'h3);
    idle(7, 3'd3);
    // Retrigger 4 cycles after the first START.
    wr(3'd3, 32'h6);
    wr(3'd2, 32'd10);
    wr(3'd3, 32'h1);
    idle(3, 3'd3);
    wr(3'd3, 32'h1);
    idle(15, 3'd3);
    // DONE_CLR on the same edge the pulse ends: set wins; later clear works.
    wr(3'd3, 32'h7);
    idle(9, 3'd3);
    wr(3'd3, 32'h6);
    idle(2, 3'd3);
    wr(3'd3, 32'h6);
    idle(2, 3'd3);
    // PLEN==0 START.
    wr(3'd2, 32'd0);
    wr(3'd3, 32'h3);
    idle(2, 3'd3);
    // Reset mid-pulse.
    wr(3'd0, 32'h5A);
    wr(3'd1, 32'hF0);
    wr(3'd2, 32'd8);
    wr(3'd3, 32'h1);
    idle(3, 3'd3);
    op(1'b0, 1'b0, 1'b1, 3'd3, '0);
    idle(3, 3'd3);
    // Unmapped addresses ignore writes.
    wr(3'd6, 32'hFFFF_FFFF);
    wr(3'd7, 32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) idle(1, 3'(i));
    // Maximum PLEN: no wrap on load, then cut short by reset.
    wr(3'd1, 32'h0C);
    wr(3'd2, 32'hFFFF_FFFF);
    wr(3'd3, 32'h1);
    idle(20, 3'd3);
    op(1'b0, 1'b0, 1'b1, 3'd2, '0);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      logic [2:0]  a;
      logic [31:0] wd;
      r  = $urandom_range(0, 99);
      a  = 3'($urandom_range(0, 7));
      wd = $urandom;
      if (a == 3'd2) wd = 32'($urandom_range(0, 12));
      if (a == 3'd3) wd = 32'($urandom_range(0, 7));
      if (r < 1) op(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, wd);
      else if (r < 45) op(1'b1, 1'($urandom_range(0, 1)), 1'b1, a, wd);
      else if (r < 50) op(1'b1, 1'b0, 1'b0, a, wd);
      else wr(a, wd);
    end
    idle(2, 3'd0);
    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
